// File: rtl/wb_arb_stage_if.sv
// Result-producer side of the writeback stage.
//
// Each of the NUM_SRC producers offers one result through this bundle.
// Handshake: a producer holds src_valid_i together with its wr_en/rd/data
// fields stable until it sees src_ready_o high. The result is consumed on
// the rising clock edge where src_valid_i[k] and src_ready_o[k] are both
// high. src_ready_o[k] is never high while src_valid_i[k] is low.
//
// Signals (per source k):
//   src_valid_i[k]                              result offered
//   src_ready_o[k]                              grant from the stage
//   src_wr_en_i[k]                              result writes rd
//   src_rd_i[k*REG_ADDR_W +: REG_ADDR_W]        destination register
//   src_data_i[k*XLEN +: XLEN]                  result value
// Modports: slave (the writeback stage), master (the producers).
interface wb_arb_stage_if #(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 3,
  parameter int REG_ADDR_W = 5
);
  logic [NUM_SRC-1:0]            src_valid_i;
  logic [NUM_SRC-1:0]            src_ready_o;
  logic [NUM_SRC-1:0]            src_wr_en_i;
  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd_i;
  logic [NUM_SRC*XLEN-1:0]       src_data_i;

  modport slave (
    input  src_valid_i,
    input  src_wr_en_i,
    input  src_rd_i,
    input  src_data_i,
    output src_ready_o
  );

  modport master (
    output src_valid_i,
    output src_wr_en_i,
    output src_rd_i,
    output src_data_i,
    input  src_ready_o
  );
endinterface

// File: rtl/wb_arb_stage.sv
// Registered writeback stage with round-robin arbitration.
//
// Picks at most one producer result per cycle, searching from rr_ptr
// upward modulo NUM_SRC, registers it, and drives the register-file write
// port, the forwarding bus and a retire counter from that register.
//
// Ports:
//   clk_i, rst_i      clock (rising edge), asynchronous active-high reset
//   src               producer bundle (slave side of wb_arb_stage_if)
//   stall_i           blocks new grants; an already-held result still writes
//   flush_i           blocks grants and empties the holding register
//   rf_wr_en_o/reg/data   register-file write port (x0 writes suppressed)
//   fwd_valid_o/wr_en/reg/data   forwarding bus view of the held result
//   retire_cnt_o      count of all retired results, wraps modulo 2^CNT_W
module wb_arb_stage #(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 3,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wb_arb_stage_if.slave         src,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  rf_wr_en_o,
  output logic [REG_ADDR_W-1:0] rf_wr_reg_o,
  output logic [XLEN-1:0]       rf_wr_data_o,
  output logic                  fwd_valid_o,
  output logic                  fwd_wr_en_o,
  output logic [REG_ADDR_W-1:0] fwd_reg_o,
  output logic [XLEN-1:0]       fwd_data_o,
  output logic [CNT_W-1:0]      retire_cnt_o
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      next_ptr;
  logic                  grant_vld;

  logic                  out_valid;
  logic                  out_wr_en;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [XLEN-1:0]       out_data;
  logic [CNT_W-1:0]      retire_cnt;

  // Round-robin search starting at rr_ptr. The reset term keeps
  // src_ready_o low while rst_i is held, since the registers alone would
  // not block a grant during reset.
  always_comb begin : arb
    int k;
    k         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!rst_i && !stall_i && !flush_i) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        k = int'(rr_ptr) + i;
        if (k >= NUM_SRC) k = k - NUM_SRC;
        if (!grant_vld && src.src_valid_i[k]) begin
          grant_vld = 1'b1;
          grant_idx = PTR_W'(k);
        end
      end
    end
  end

  assign next_ptr        = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
  assign src.src_ready_o = grant_vld ? (NUM_SRC'(1) << grant_idx) : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid  <= 1'b0;
      out_wr_en  <= 1'b0;
      out_rd     <= '0;
      out_data   <= '0;
      rr_ptr     <= '0;
      retire_cnt <= '0;
    end else if (grant_vld) begin
      out_valid  <= 1'b1;
      out_wr_en  <= src.src_wr_en_i[grant_idx];
      out_rd     <= src.src_rd_i[grant_idx*REG_ADDR_W +: REG_ADDR_W];
      out_data   <= src.src_data_i[grant_idx*XLEN +: XLEN];
      rr_ptr     <= next_ptr;
      retire_cnt <= retire_cnt + 1'b1;
    end else begin
      // Index/data/wr_en hold so the forwarding bus stays quiet between results.
      out_valid  <= 1'b0;
    end
  end

  assign rf_wr_en_o   = out_valid & out_wr_en & (out_rd != '0);
  assign rf_wr_reg_o  = out_rd;
  assign rf_wr_data_o = out_data;
  assign fwd_valid_o  = out_valid;
  assign fwd_wr_en_o  = out_wr_en & (out_rd != '0);
  assign fwd_reg_o    = out_rd;
  assign fwd_data_o   = out_data;
  assign retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_wb_arb_stage.sv
// Bench for wb_arb_stage (NUM_SRC=3, CNT_W=4 so the counter wrap is reachable).
module tb_wb_arb_stage;
  localparam int XLEN = 32;
  localparam int NS   = 3;
  localparam int RW   = 5;
  localparam int CW   = 4;

  localparam logic [31:0] DA = 32'hDEAD_BEEF;
  localparam logic [31:0] C1 = 32'hC000_0001;
  localparam logic [31:0] C2 = 32'hC000_0002;
  localparam logic [31:0] C3 = 32'hC000_0003;
  localparam logic [31:0] C7 = 32'hC000_0007;
  localparam logic [31:0] X0 = 32'h0000_1234;

  // clock / reset
  logic clk = 1'b0;
  logic rst_i;
  logic stall_i, flush_i;
  always #5 clk = ~clk;

  wb_arb_stage_if #(.XLEN(XLEN), .NUM_SRC(NS), .REG_ADDR_W(RW)) bus ();

  logic          rf_wr_en_o;
  logic [RW-1:0] rf_wr_reg_o;
  logic [31:0]   rf_wr_data_o;
  logic          fwd_valid_o, fwd_wr_en_o;
  logic [RW-1:0] fwd_reg_o;
  logic [31:0]   fwd_data_o;
  logic [CW-1:0] retire_cnt_o;

  wb_arb_stage #(.XLEN(XLEN), .NUM_SRC(NS), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .src          (bus),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .rf_wr_en_o   (rf_wr_en_o),
    .rf_wr_reg_o  (rf_wr_reg_o),
    .rf_wr_data_o (rf_wr_data_o),
    .fwd_valid_o  (fwd_valid_o),
    .fwd_wr_en_o  (fwd_wr_en_o),
    .fwd_reg_o    (fwd_reg_o),
    .fwd_data_o   (fwd_data_o),
    .retire_cnt_o (retire_cnt_o)
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // vector table
  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  wr_en;
    logic [14:0] rd;
    logic [95:0] data;
    logic        stall;
    logic        flush;
    logic [2:0]  e_ready;
    logic        e_rf;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        e_fv;
    logic        e_fwe;
    logic [3:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(logic [2:0] valid, logic [2:0] wr_en, logic [14:0] rd,
                              logic [95:0] data, logic stall, logic flush,
                              logic [2:0] e_ready, logic e_rf, logic [4:0] e_reg,
                              logic [31:0] e_data, logic e_fv, logic e_fwe, logic [3:0] e_cnt);
    vec_t v;
    v.valid = valid; v.wr_en = wr_en; v.rd = rd; v.data = data;
    v.stall = stall; v.flush = flush; v.e_ready = e_ready; v.e_rf = e_rf;
    v.e_reg = e_reg; v.e_data = e_data; v.e_fv = e_fv; v.e_fwe = e_fwe; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t vecs[17];

  // driver tasks
  task automatic drive(input logic [2:0] valid, input logic [2:0] wr_en, input logic [14:0] rd,
                       input logic [95:0] data, input logic stall, input logic flush);
    bus.src_valid_i = valid;
    bus.src_wr_en_i = wr_en;
    bus.src_rd_i    = rd;
    bus.src_data_i  = data;
    stall_i         = stall;
    flush_i         = flush;
  endtask

  task automatic check_outputs(input string tag, input logic e_rf, input logic [4:0] e_reg,
                               input logic [31:0] e_data, input logic e_fv, input logic e_fwe,
                               input logic [3:0] e_cnt);
    chk({tag, " rf_wr_en"},   64'(rf_wr_en_o),   64'(e_rf));
    chk({tag, " rf_wr_reg"},  64'(rf_wr_reg_o),  64'(e_reg));
    chk({tag, " rf_wr_data"}, 64'(rf_wr_data_o), 64'(e_data));
    chk({tag, " fwd_valid"},  64'(fwd_valid_o),  64'(e_fv));
    chk({tag, " fwd_wr_en"},  64'(fwd_wr_en_o),  64'(e_fwe));
    chk({tag, " fwd_reg"},    64'(fwd_reg_o),    64'(e_reg));
    chk({tag, " fwd_data"},   64'(fwd_data_o),   64'(e_data));
    chk({tag, " retire_cnt"}, 64'(retire_cnt_o), 64'(e_cnt));
  endtask

  // Drive, check the combinational grant, take one edge, check registers.
  task automatic apply(input vec_t v, input string tag);
    drive(v.valid, v.wr_en, v.rd, v.data, v.stall, v.flush);
    #1;
    chk({tag, " ready"}, 64'(bus.src_ready_o), 64'(v.e_ready));
    @(posedge clk);
    #1;
    check_outputs(tag, v.e_rf, v.e_reg, v.e_data, v.e_fv, v.e_fwe, v.e_cnt);
  endtask

  initial begin
    logic [14:0] r0, r1, r2, r3;
    logic [95:0] d0, d1, d2, d3;
    int          grants[7];
    logic [3:0]  cnts[7];
    r0 = {5'd3, 5'd2, 5'd5}; d0 = {C3, C2, DA};
    r1 = {5'd3, 5'd2, 5'd1}; d1 = {C3, C2, C1};
    r2 = {5'd7, 5'd2, 5'd1}; d2 = {C7, C2, C1};
    r3 = {5'd7, 5'd2, 5'd0}; d3 = {C7, C2, X0};

    //                 valid   wr      rd  data st fl  ready  rf reg   data fv fwe cnt
    vecs[0]  = mk(3'b001, 3'b111, r0, d0, 0, 0, 3'b001, 1, 5'd5, DA, 1, 1, 4'd1);
    vecs[1]  = mk(3'b000, 3'b111, r0, d0, 0, 0, 3'b000, 0, 5'd5, DA, 0, 1, 4'd1);
    vecs[2]  = mk(3'b111, 3'b111, r1, d1, 0, 0, 3'b010, 1, 5'd2, C2, 1, 1, 4'd2);
    vecs[3]  = mk(3'b111, 3'b111, r1, d1, 0, 0, 3'b100, 1, 5'd3, C3, 1, 1, 4'd3);
    vecs[4]  = mk(3'b111, 3'b111, r1, d1, 0, 0, 3'b001, 1, 5'd1, C1, 1, 1, 4'd4);
    vecs[5]  = mk(3'b111, 3'b111, r1, d1, 0, 0, 3'b010, 1, 5'd2, C2, 1, 1, 4'd5);
    vecs[6]  = mk(3'b010, 3'b111, r1, d1, 1, 0, 3'b000, 0, 5'd2, C2, 0, 1, 4'd5);
    vecs[7]  = mk(3'b010, 3'b111, r1, d1, 1, 0, 3'b000, 0, 5'd2, C2, 0, 1, 4'd5);
    vecs[8]  = mk(3'b010, 3'b111, r1, d1, 1, 0, 3'b000, 0, 5'd2, C2, 0, 1, 4'd5);
    vecs[9]  = mk(3'b010, 3'b111, r1, d1, 0, 0, 3'b010, 1, 5'd2, C2, 1, 1, 4'd6);
    vecs[10] = mk(3'b000, 3'b111, r1, d1, 0, 0, 3'b000, 0, 5'd2, C2, 0, 1, 4'd6);
    vecs[11] = mk(3'b100, 3'b111, r2, d2, 0, 0, 3'b100, 1, 5'd7, C7, 1, 1, 4'd7);
    vecs[12] = mk(3'b100, 3'b111, r2, d2, 0, 1, 3'b000, 0, 5'd7, C7, 0, 1, 4'd7);
    vecs[13] = mk(3'b100, 3'b111, r2, d2, 1, 1, 3'b000, 0, 5'd7, C7, 0, 1, 4'd7);
    vecs[14] = mk(3'b100, 3'b111, r2, d2, 0, 0, 3'b100, 1, 5'd7, C7, 1, 1, 4'd8);
    vecs[15] = mk(3'b001, 3'b111, r3, d3, 0, 0, 3'b001, 0, 5'd0, X0, 1, 0, 4'd9);
    vecs[16] = mk(3'b010, 3'b000, r3, d3, 0, 0, 3'b010, 0, 5'd2, C2, 1, 0, 4'd10);

    // reset with a source already valid: nothing may be granted or written
    rst_i = 1'b1;
    drive(3'b111, 3'b111, r0, d0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 64'(bus.src_ready_o), 64'd0);
    check_outputs("reset", 0, 5'd0, 32'd0, 0, 0, 4'd0);
    @(negedge clk);
    rst_i = 1'b0;
    drive(3'b000, 3'b000, r0, d0, 0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // All three valid continuously from rr_ptr=2: back-to-back writes and
    // the counter wrapping 15 -> 0 -> 1.
    grants = '{2, 0, 1, 2, 0, 1, 2};
    cnts   = '{4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
    drive(3'b111, 3'b111, r1, d1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk($sformatf("rr%0d ready", i), 64'(bus.src_ready_o), 64'(3'b001 << grants[i]));
      @(posedge clk);
      #1;
      check_outputs($sformatf("rr%0d", i), 1, 5'(grants[i] + 1),
                    (grants[i] == 0) ? C1 : (grants[i] == 1) ? C2 : C3, 1, 1, cnts[i]);
    end

    // Reset between grant and write: the pending capture is dropped.
    drive(3'b001, 3'b111, r0, d0, 0, 0);
    #1;
    chk("midrst ready pre", 64'(bus.src_ready_o), 64'(3'b001));
    rst_i = 1'b1;
    #1;
    chk("midrst ready", 64'(bus.src_ready_o), 64'd0);
    check_outputs("midrst async", 0, 5'd0, 32'd0, 0, 0, 4'd0);
    @(posedge clk);
    #1;
    check_outputs("midrst edge", 0, 5'd0, 32'd0, 0, 0, 4'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // After release the pointer starts at 0 again.
    drive(3'b011, 3'b111, r0, d0, 0, 0);
    #1;
    chk("postrst ready", 64'(bus.src_ready_o), 64'(3'b001));
    @(posedge clk);
    #1;
    check_outputs("postrst", 1, 5'd5, DA, 1, 1, 4'd1);
    drive(3'b000, 3'b111, r0, d0, 0, 0);
    @(posedge clk);
    #1;
    chk("postrst pulse end", 64'(rf_wr_en_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  // Hard time limit in case a clocking problem stalls the sequence.
  initial begin
    #100000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end
endmodule
